// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types for the round-robin 4:1 mux arbiter.
// Holds the arbiter state encoding and the requester count.
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int NREQ = 4;

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Requester/consumer bundle for the round-robin mux arbiter.
// The master modport is the arbiter side; the slave modport is its environment.
interface rr_mux4_arbiter_if #(
    parameter int N = 10
);
    import arb_pkg::*;

    logic [NREQ-1:0] req;
    logic [N-1:0]    d0;
    logic [N-1:0]    d1;
    logic [N-1:0]    d2;
    logic [N-1:0]    d3;
    logic [NREQ-1:0] ack;
    logic [1:0]      sel;
    logic [N-1:0]    y;
    logic            out_valid;
    logic            out_ready;
    logic            err;

    modport master (
        input  req, d0, d1, d2, d3, out_ready,
        output ack, sel, y, out_valid, err
    );

    modport slave (
        output req, d0, d1, d2, d3, out_ready,
        input  ack, sel, y, out_valid, err
    );

endinterface

// File: rtl/rr_mux4_arbiter_pick.sv
// Round-robin pick: rotate req by ptr, take the lowest set bit,
// then rotate the index back so the search order is ptr, ptr+1, ...
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[3:0];
        off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) off = 2'(k);
        end
        any     = |req;
        gnt_idx = ptr + off;
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux onto a valid/ready port,
// with a stall watchdog that aborts a transfer the consumer never takes.
module rr_mux4_arbiter
    import arb_pkg::*;
#(
    parameter int N       = 10,
    parameter int TIMEOUT = 15
) (
    input logic              clk,
    input logic              reset,
    rr_mux4_arbiter_if.master bus
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    arb_state_t      state;
    arb_state_t      state_n;
    logic [1:0]      ptr;
    logic [1:0]      ptr_n;
    logic [1:0]      sel;
    logic [1:0]      sel_n;
    logic [WW-1:0]   wdog;
    logic [WW-1:0]   wdog_n;
    logic [1:0]      gnt;
    logic            any;
    logic [NREQ-1:0] ack_c;
    logic            err_c;

    rr_pick4 u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .gnt_idx (gnt),
        .any     (any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            wdog  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            wdog  <= wdog_n;
        end
    end

    // Accept beats withdrawal and timeout when they coincide.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        wdog_n  = wdog;
        if (state == IDLE) begin
            if (any) begin
                sel_n   = gnt;
                state_n = BUSY;
                wdog_n  = '0;
            end
        end else begin
            if (bus.out_ready) begin
                ptr_n   = sel + 2'd1;
                state_n = IDLE;
            end else if (!bus.req[sel]) begin
                state_n = IDLE;
            end else if (wdog == WLAST) begin
                ptr_n   = sel + 2'd1;
                state_n = IDLE;
            end else begin
                wdog_n = wdog + WW'(1);
            end
        end
    end

    always_comb begin
        ack_c = '0;
        err_c = 1'b0;
        if (state == BUSY) begin
            if (bus.out_ready) begin
                ack_c[sel] = 1'b1;
            end else if (bus.req[sel] && wdog == WLAST) begin
                err_c = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    bus.y = bus.d0;
            2'd1:    bus.y = bus.d1;
            2'd2:    bus.y = bus.d2;
            default: bus.y = bus.d3;
        endcase
    end

    assign bus.ack       = ack_c;
    assign bus.err       = err_c;
    assign bus.sel       = sel;
    assign bus.out_valid = (state == BUSY);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter with a cycle-level reference model
// of round-robin grant, accept, withdrawal and watchdog abort.
module tb_rr_mux4_arbiter;

    logic clk;
    logic reset;
    logic [9:0] dv [4];

    int checks;
    int errors;

    int m_busy;
    int m_g;
    int m_ptr;
    int m_stall;

    rr_mux4_arbiter_if #(.N(10)) bus ();

    rr_mux4_arbiter #(
        .N       (10),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.d0 = dv[0];
    assign bus.d1 = dv[1];
    assign bus.d2 = dv[2];
    assign bus.d3 = dv[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_g     = 0;
        m_ptr   = 0;
        m_stall = 0;
    endtask

    task automatic model_adv();
        bit found;
        if (reset) begin
            model_reset();
        end else if (m_busy == 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && bus.req[(m_ptr + k) % 4]) begin
                    found   = 1;
                    m_g     = (m_ptr + k) % 4;
                    m_busy  = 1;
                    m_stall = 0;
                end
            end
        end else if (bus.out_ready) begin
            m_ptr  = (m_g + 1) % 4;
            m_busy = 0;
        end else if (!bus.req[m_g]) begin
            m_busy = 0;
        end else if (m_stall == 3) begin
            m_ptr  = (m_g + 1) % 4;
            m_busy = 0;
        end else begin
            m_stall++;
        end
    endtask

    task automatic settle();
        int exp_ack;
        int exp_err;
        @(negedge clk);
        if (reset) model_reset();
        exp_ack = (m_busy != 0 && bus.out_ready) ? (1 << m_g) : 0;
        exp_err = (m_busy != 0 && !bus.out_ready && bus.req[m_g]
                   && m_stall == 3) ? 1 : 0;
        chk("m_valid", int'(bus.out_valid), m_busy);
        chk("m_sel", int'(bus.sel), m_g);
        chk("m_y", int'(bus.y), int'(dv[m_g]));
        chk("m_ack", int'(bus.ack), exp_ack);
        chk("m_err", int'(bus.err), exp_err);
    endtask

    task automatic edge_();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        for (int i = 0; i < 4; i++) dv[i] = '0;
        reset         = 1'b1;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b0;

        // reset held with all requests
        edge_();
        settle();
        chk("t1_rst_valid", int'(bus.out_valid), 0);
        chk("t1_rst_ack", int'(bus.ack), 0);
        chk("t1_rst_sel", int'(bus.sel), 0);
        edge_();
        reset = 1'b0;
        settle();
        edge_();
        settle();
        chk("t1_sel", int'(bus.sel), 0);
        chk("t1_valid", int'(bus.out_valid), 1);
        bus.req = 4'b0000;
        edge_();

        // single requester, immediate accept
        bus.req       = 4'b0100;
        dv[2]         = 10'h3FF;
        bus.out_ready = 1'b1;
        settle();
        edge_();
        settle();
        chk("t2_y", int'(bus.y), 'h3FF);
        chk("t2_valid", int'(bus.out_valid), 1);
        chk("t2_ack", int'(bus.ack), 4'b0100);
        edge_();
        bus.req = 4'b0000;
        settle();
        chk("t2_idle", int'(bus.out_valid), 0);
        edge_();

        // fresh pointer, all requesting
        reset = 1'b1;
        settle();
        edge_();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) dv[i] = 10'(i);
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            edge_();
            settle();
            chk("t3_sel", int'(bus.sel), k % 4);
            chk("t3_y", int'(bus.y), k % 4);
            chk("t3_ack", int'(bus.ack), 1 << (k % 4));
            edge_();
        end

        // watchdog abort on requester 1
        bus.req       = 4'b0010;
        bus.out_ready = 1'b0;
        settle();
        edge_();
        for (int b = 1; b <= 4; b++) begin
            settle();
            chk("t4_err", int'(bus.err), (b == 4) ? 1 : 0);
            chk("t4_ack", int'(bus.ack), 0);
            edge_();
        end
        bus.req = 4'b0011;
        settle();
        edge_();
        bus.out_ready = 1'b1;
        settle();
        chk("t4_wrap_sel", int'(bus.sel), 0);
        chk("t4_wrap_ack", int'(bus.ack), 4'b0001);
        edge_();
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;

        // withdrawal on requester 3 keeps the pointer
        bus.req = 4'b1000;
        settle();
        edge_();
        settle();
        edge_();
        bus.req = 4'b0000;
        settle();
        chk("t5_ack", int'(bus.ack), 0);
        chk("t5_err", int'(bus.err), 0);
        edge_();
        bus.req = 4'b1001;
        settle();
        chk("t5_idle", int'(bus.out_valid), 0);
        edge_();
        settle();
        chk("t5_regrant", int'(bus.sel), 3);
        edge_();

        // async reset mid-transfer
        reset = 1'b1;
        #1;
        chk("t6_async_valid", int'(bus.out_valid), 0);
        chk("t6_async_ack", int'(bus.ack), 0);
        settle();
        edge_();
        reset = 1'b0;
        settle();
        chk("t6_sel", int'(bus.sel), 0);
        chk("t6_valid", int'(bus.out_valid), 0);
        edge_();
        settle();
        chk("t6_grant", int'(bus.sel), 0);
        chk("t6_busy", int'(bus.out_valid), 1);
        bus.req = 4'b0000;
        edge_();
        settle();
        edge_();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
